// File: rtl/pixel_seq_ctrl.sv
// pixel_seq_ctrl: frame sequencer for the 2x2 pixel array and its column ADC.
// Walks IDLE -> ERASE -> EXPOSE -> CONVERT -> READ12 -> READ34 -> DONE and
// decodes every output from the registered state, phase counter and exposure
// register, so no input reaches an output combinationally.
module pixel_seq_ctrl #(
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_DEFAULT  = 16,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 255,
  parameter int ADC_BITS     = 8,
  parameter int READ_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                exp_increase,
  input  logic                exp_decrease,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic                read12,
  output logic                read34,
  output logic                anaReset,
  output logic                anaBias1,
  output logic                anaRamp,
  output logic [ADC_BITS-1:0] adc_count,
  output logic [7:0]          exp_time,
  output logic                busy,
  output logic                frame_done
);

  localparam int CONV_LEN = 1 << ADC_BITS;
  localparam int LEN_M1   = (CONV_LEN > EXP_MAX) ? CONV_LEN : EXP_MAX;
  localparam int LEN_M2   = (LEN_M1 > ERASE_CYCLES) ? LEN_M1 : ERASE_CYCLES;
  localparam int MAX_LEN  = (LEN_M2 > READ_CYCLES) ? LEN_M2 : READ_CYCLES;
  // Counter only has to reach MAX_LEN-1 before it is cleared.
  localparam int CW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ12  = 3'd4,
    S_READ34  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_exp;
  logic [7:0]      r_exp_lat;
  logic [CW:0]     w_len;
  logic            w_last;

  // Length of the current phase; EXPOSE uses the value captured on leaving IDLE.
  always_comb begin
    w_len = (CW+1)'(1);
    case (r_state)
      S_ERASE:   w_len = (CW+1)'(ERASE_CYCLES);
      S_EXPOSE:  w_len = (CW+1)'(r_exp_lat);
      S_CONVERT: w_len = (CW+1)'(CONV_LEN);
      S_READ12:  w_len = (CW+1)'(READ_CYCLES);
      S_READ34:  w_len = (CW+1)'(READ_CYCLES);
      default:   w_len = (CW+1)'(1);
    endcase
    w_last = ({1'b0, r_cnt} == (w_len - (CW+1)'(1)));
  end

  // Next-state logic: leave a phase when its counter reaches length-1.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (init)   w_state_next = S_ERASE;
      S_ERASE:   if (w_last) w_state_next = S_EXPOSE;
      S_EXPOSE:  if (w_last) w_state_next = S_CONVERT;
      S_CONVERT: if (w_last) w_state_next = S_READ12;
      S_READ12:  if (w_last) w_state_next = S_READ34;
      S_READ34:  if (w_last) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Phase counter: cleared on every transition and held at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || (w_state_next != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Exposure register: saturating inc/dec in IDLE only; latch the old value on frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp     <= 8'(EXP_DEFAULT);
      r_exp_lat <= 8'(EXP_DEFAULT);
    end else if (r_state == S_IDLE) begin
      if (init) begin
        r_exp_lat <= r_exp;
      end
      if (exp_increase && !exp_decrease) begin
        if (r_exp < 8'(EXP_MAX)) begin
          r_exp <= r_exp + 8'd1;
        end
      end else if (exp_decrease && !exp_increase) begin
        if (r_exp > 8'(EXP_MIN)) begin
          r_exp <= r_exp - 8'd1;
        end
      end
    end
  end

  // Output decode from registered state and counter.
  always_comb begin
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    read12     = 1'b0;
    read34     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    adc_count  = '0;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_ERASE:   erase = 1'b1;
      S_EXPOSE:  expose = 1'b1;
      S_CONVERT: begin
        convert   = 1'b1;
        adc_count = r_cnt[ADC_BITS-1:0];
      end
      S_READ12:  read12 = 1'b1;
      S_READ34:  read34 = 1'b1;
      S_DONE:    frame_done = 1'b1;
      default:   busy = 1'b0;
    endcase
    anaReset = erase;
    anaBias1 = expose;
    anaRamp  = convert;
    exp_time = r_exp;
  end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// tb_pixel_seq_ctrl: table-driven, hand-written and random checks of the
// frame sequencer against a frame-position reference model.
module tb_pixel_seq_ctrl;

  localparam int ERASE_C = 5;
  localparam int EXP_DEF = 16;
  localparam int EXP_MN  = 2;
  localparam int EXP_MX  = 255;
  localparam int ADCB    = 8;
  localparam int READ_C  = 2;
  localparam int CONV_C  = 1 << ADCB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0;
  logic exp_increase = 1'b0;
  logic exp_decrease = 1'b0;
  logic erase, expose, convert, read12, read34;
  logic anaReset, anaBias1, anaRamp, busy, frame_done;
  logic [ADCB-1:0] adc_count;
  logic [7:0] exp_time;

  pixel_seq_ctrl #(
    .ERASE_CYCLES(ERASE_C), .EXP_DEFAULT(EXP_DEF), .EXP_MIN(EXP_MN),
    .EXP_MAX(EXP_MX), .ADC_BITS(ADCB), .READ_CYCLES(READ_C)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .exp_increase(exp_increase), .exp_decrease(exp_decrease),
    .erase(erase), .expose(expose), .convert(convert),
    .read12(read12), .read34(read34),
    .anaReset(anaReset), .anaBias1(anaBias1), .anaRamp(anaRamp),
    .adc_count(adc_count), .exp_time(exp_time),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_count = 0;
  int last_done  = -1;

  // Reference model: position inside the frame (-1 = idle) plus exposure values.
  int m_pos = -1;
  int m_lat = EXP_DEF;
  int m_exp = EXP_DEF;

  function automatic int frame_len(input int e);
    return ERASE_C + e + CONV_C + 2*READ_C + 1;
  endfunction

  function automatic logic [25:0] model_out();
    logic e, x, c, r1, r3, b, fd;
    logic [7:0] a;
    e = 0; x = 0; c = 0; r1 = 0; r3 = 0; b = 0; fd = 0; a = 8'd0;
    if (m_pos >= 0) begin
      b = 1;
      if (m_pos < ERASE_C) e = 1;
      else if (m_pos < ERASE_C + m_lat) x = 1;
      else if (m_pos < ERASE_C + m_lat + CONV_C) begin
        c = 1;
        a = 8'(m_pos - ERASE_C - m_lat);
      end
      else if (m_pos < ERASE_C + m_lat + CONV_C + READ_C) r1 = 1;
      else if (m_pos < ERASE_C + m_lat + CONV_C + 2*READ_C) r3 = 1;
      else fd = 1;
    end
    return {e, x, c, r1, r3, e, x, c, b, fd, a, 8'(m_exp)};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {erase, expose, convert, read12, read34, anaReset, anaBias1,
            anaRamp, busy, frame_done, adc_count, exp_time};
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // One clock: drive inputs, step the model, sample DUT 1 time unit after the edge.
  task automatic tick(input logic r, input logic i, input logic u, input logic d);
    reset = r; init = i; exp_increase = u; exp_decrease = d;
    @(posedge clk);
    if (r) begin
      m_pos = -1;
      m_exp = EXP_DEF;
    end else if (m_pos < 0) begin
      if (i) begin
        m_pos = 0;
        m_lat = m_exp;
      end
      if (u && !d && m_exp < EXP_MX) m_exp++;
      else if (d && !u && m_exp > EXP_MN) m_exp--;
    end else begin
      m_pos++;
      if (m_pos == frame_len(m_lat)) m_pos = -1;
    end
    cyc++;
    #1;
    check_val("outputs", 32'(dut_vec()), 32'(model_out()));
    check_val("phase_mutex", 32'($countones({erase, expose, convert, read12, read34}) <= 1), 32'd1);
    if (frame_done) begin
      done_count++;
      last_done = cyc;
    end
  endtask

  typedef struct {
    string name;
    logic  r, i, u, d;
    int    n;
    int    exp_after;
    int    dones;
  } vec_t;

  vec_t tbl[11];

  // Phase bookkeeping for the explicit timing sequence (0 erase .. 5 frame_done).
  int first_seen[6];
  int high_cnt[6];
  int busy_low_at;

  task automatic note(input int rel);
    logic [5:0] ph;
    ph = {frame_done, read34, read12, convert, expose, erase};
    for (int k = 0; k < 6; k++) begin
      if (ph[k]) begin
        if (first_seen[k] < 0) first_seen[k] = rel;
        high_cnt[k]++;
      end
    end
    if (!busy && busy_low_at < 0) busy_low_at = rel;
  endtask

  initial begin
    int d0, found, rel, t0, expose_cnt;
    int req_first[6];
    int req_cnt[6];
    int dones[3];

    tbl[0]  = '{"reset",         1, 0, 0, 0,   2,  16, 0};
    tbl[1]  = '{"init_pulse",    0, 1, 0, 0,   1,  16, 0};
    tbl[2]  = '{"frame1",        0, 0, 0, 0, 290,  16, 1};
    tbl[3]  = '{"inc_sat",       0, 0, 1, 0, 300, 255, 0};
    tbl[4]  = '{"dec_sat",       0, 0, 0, 1, 300,   2, 0};
    tbl[5]  = '{"reset2",        1, 0, 0, 0,   1,  16, 0};
    tbl[6]  = '{"inc_and_dec",   0, 0, 1, 1, 300,  16, 0};
    tbl[7]  = '{"init_with_inc", 0, 1, 1, 0,   1,  17, 0};
    tbl[8]  = '{"inc_in_frame",  0, 0, 1, 0,  20,  17, 0};
    tbl[9]  = '{"init_in_frame", 0, 1, 0, 0, 100,  17, 0};
    tbl[10] = '{"frame2_end",    0, 0, 0, 0, 200,  17, 1};

    for (int v = 0; v < 11; v++) begin
      d0 = done_count;
      for (int k = 0; k < tbl[v].n; k++) tick(tbl[v].r, tbl[v].i, tbl[v].u, tbl[v].d);
      check_val({tbl[v].name, "_exp"}, 32'(exp_time), 32'(tbl[v].exp_after));
      check_val({tbl[v].name, "_dones"}, 32'(done_count - d0), 32'(tbl[v].dones));
      $display("vector %0d %s: exp_time=%0d frame_done_count=%0d", v, tbl[v].name, exp_time, done_count - d0);
    end

    // Explicit frame timing with default exposure, rel 1 = first cycle after init edge.
    tick(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin first_seen[k] = -1; high_cnt[k] = 0; end
    busy_low_at = -1;
    req_first = '{1, 6, 22, 278, 280, 282};
    req_cnt   = '{5, 16, 256, 2, 2, 1};
    tick(0, 1, 0, 0);
    note(1);
    for (int r2 = 2; r2 <= 290; r2++) begin
      tick(0, 0, 0, 0);
      note(r2);
    end
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("timing_first_%0d", k), 32'(first_seen[k]), 32'(req_first[k]));
      check_val($sformatf("timing_len_%0d", k), 32'(high_cnt[k]), 32'(req_cnt[k]));
    end
    check_val("busy_low_at", 32'(busy_low_at), 32'd283);
    $display("sequence timing: done at %0d busy low at %0d", first_seen[5], busy_low_at);

    // Reset during CONVERT at adc_count=100, then a full frame.
    tick(0, 1, 0, 0);
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(0, 0, 0, 0);
      if (convert && adc_count == 8'd100) found = 1;
    end
    check_val("reach_adc100", 32'(found), 32'd1);
    d0 = done_count;
    tick(1, 0, 0, 0);
    check_val("rst_in_convert", 32'(dut_vec()), {6'd0, 18'd0, 8'd16});
    tick(0, 1, 0, 0);
    rel = 1;
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (frame_done) found = 1;
      else begin
        tick(0, 0, 0, 0);
        rel++;
      end
    end
    check_val("post_rst_frame_len", 32'(rel), 32'd282);
    check_val("post_rst_one_done", 32'(done_count - d0), 32'd1);
    $display("sequence reset_in_convert: frame_done at rel %0d", rel);

    // init and exp_increase together: EXPOSE uses old value 16, register reads 17.
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 0);
    expose_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick(0, 0, 0, 0);
      if (expose) expose_cnt++;
    end
    check_val("init_inc_expose_len", 32'(expose_cnt), 32'd16);
    check_val("init_inc_exp_time", 32'(exp_time), 32'd17);
    $display("sequence init_with_inc: expose=%0d exp_time=%0d", expose_cnt, exp_time);

    // Back-to-back frames with init held high.
    tick(1, 0, 0, 0);
    d0 = done_count;
    t0 = 0;
    for (int k = 0; k < 1000 && t0 < 3; k++) begin
      tick(0, 1, 0, 0);
      if (frame_done) begin
        dones[t0] = cyc;
        t0++;
      end
    end
    check_val("b2b_done_count", 32'(t0), 32'd3);
    if (t0 == 3) begin
      check_val("b2b_spacing_1", 32'(dones[1] - dones[0]), 32'd283);
      check_val("b2b_spacing_2", 32'(dones[2] - dones[1]), 32'd283);
    end
    $display("sequence back_to_back: %0d frames", t0);

    // Random stimulus checked cycle by cycle against the model.
    tick(1, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    $display("random phase: %0d frames completed in total", done_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
